// File: rtl/ahb_master_cmd_arbiter.sv
// Two-requester command arbiter in front of the AHB master transfer engine.
// Grants one command at a time, launches it, watches for done/error/timeout and returns a completion.
module ahb_master_cmd_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_write,
    input  logic [2:0]        req0_size,
    input  logic [2:0]        req0_burst,
    input  logic [3:0]        req0_len,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_write,
    input  logic [2:0]        req1_size,
    input  logic [2:0]        req1_burst,
    input  logic [3:0]        req1_len,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_write,
    output logic [2:0]        m_size,
    output logic [2:0]        m_burst,
    output logic [3:0]        m_burst_len,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_err,
    output logic              cpl_valid,
    output logic              cpl_id,
    output logic              cpl_err,
    output logic              cpl_timeout
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CPL} state_t;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] wd_cnt;
    logic             sticky_err;
    logic             timeout_flag;
    logic             badlen;
    logic             grant_id;
    logic             accept;
    logic             wd_hit;

    // Round-robin favours whoever was not served last; fixed priority always favours req0.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    assign accept      = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready  = (state == IDLE) && req1_valid && grant_id;
    assign m_start     = (state == LAUNCH) && !m_busy;
    assign cpl_valid   = (state == CPL);
    assign cpl_err     = cpl_valid && (sticky_err || timeout_flag || badlen);
    assign cpl_timeout = cpl_valid && timeout_flag;
    assign wd_hit      = (TIMEOUT != 0) && (wd_cnt >= CNT_MAX);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            wd_cnt       <= '0;
            sticky_err   <= 1'b0;
            timeout_flag <= 1'b0;
            badlen       <= 1'b0;
            cpl_id       <= 1'b0;
            m_addr       <= '0;
            m_write      <= 1'b0;
            m_size       <= '0;
            m_burst      <= '0;
            m_burst_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cpl_id      <= grant_id;
                        m_addr      <= grant_id ? req1_addr  : req0_addr;
                        m_write     <= grant_id ? req1_write : req0_write;
                        m_size      <= grant_id ? req1_size  : req0_size;
                        m_burst     <= grant_id ? req1_burst : req0_burst;
                        m_burst_len <= grant_id ? req1_len   : req0_len;
                        if ((grant_id ? req1_len : req0_len) == 4'd0) begin
                            badlen <= 1'b1;
                            state  <= CPL;
                        end else begin
                            state  <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    // The start cycle itself counts as watchdog cycle 0.
                    if (!m_busy) begin
                        wd_cnt <= CNT_W'(1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_err)
                        sticky_err <= 1'b1;
                    if (m_done) begin
                        state <= CPL;
                    end else if (wd_hit) begin
                        timeout_flag <= 1'b1;
                        state        <= CPL;
                    end else if (wd_cnt < CNT_MAX) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                CPL: begin
                    last_grant   <= cpl_id;
                    sticky_err   <= 1'b0;
                    timeout_flag <= 1'b0;
                    badlen       <= 1'b0;
                    wd_cnt       <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_cmd_arbiter.sv
// Scoreboard bench: a round-robin DUT with an 8-cycle watchdog plus a fixed-priority DUT
// with the watchdog disabled, both fed from the same requester and master stimulus.
module tb_ahb_master_cmd_arbiter;

    typedef struct {
        logic id;
        logic err;
        logic to;
    } exp_t;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_addr = '0, req1_addr = '0;
    logic       req0_write = 1'b0, req1_write = 1'b0;
    logic [2:0] req0_size = '0, req1_size = '0;
    logic [2:0] req0_burst = '0, req1_burst = '0;
    logic [3:0] req0_len = '0, req1_len = '0;
    logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

    logic       a_req0_ready, a_req1_ready, a_m_start, a_m_write;
    logic [7:0] a_m_addr;
    logic [2:0] a_m_size, a_m_burst;
    logic [3:0] a_m_burst_len;
    logic       a_cpl_valid, a_cpl_id, a_cpl_err, a_cpl_timeout;

    logic       f_req0_ready, f_req1_ready, f_m_start, f_m_write;
    logic [7:0] f_m_addr;
    logic [2:0] f_m_size, f_m_burst;
    logic [3:0] f_m_burst_len;
    logic       f_cpl_valid, f_cpl_id, f_cpl_err, f_cpl_timeout;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 HCLK = ~HCLK;

    ahb_master_cmd_arbiter #(.ADDR_W(8), .TIMEOUT(8), .FIXED_PRIO(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_addr(req0_addr),
        .req0_write(req0_write), .req0_size(req0_size), .req0_burst(req0_burst), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_addr(req1_addr),
        .req1_write(req1_write), .req1_size(req1_size), .req1_burst(req1_burst), .req1_len(req1_len),
        .m_start(a_m_start), .m_addr(a_m_addr), .m_write(a_m_write), .m_size(a_m_size),
        .m_burst(a_m_burst), .m_burst_len(a_m_burst_len),
        .m_busy(m_busy), .m_done(m_done), .m_err(m_err),
        .cpl_valid(a_cpl_valid), .cpl_id(a_cpl_id), .cpl_err(a_cpl_err), .cpl_timeout(a_cpl_timeout)
    );

    ahb_master_cmd_arbiter #(.ADDR_W(8), .TIMEOUT(0), .FIXED_PRIO(1)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_addr(req0_addr),
        .req0_write(req0_write), .req0_size(req0_size), .req0_burst(req0_burst), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_addr(req1_addr),
        .req1_write(req1_write), .req1_size(req1_size), .req1_burst(req1_burst), .req1_len(req1_len),
        .m_start(f_m_start), .m_addr(f_m_addr), .m_write(f_m_write), .m_size(f_m_size),
        .m_burst(f_m_burst), .m_burst_len(f_m_burst_len),
        .m_busy(m_busy), .m_done(m_done), .m_err(m_err),
        .cpl_valid(f_cpl_valid), .cpl_id(f_cpl_id), .cpl_err(f_cpl_err), .cpl_timeout(f_cpl_timeout)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_len = '0; req1_len = '0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        sbq.delete();
        #12;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        tick();
    endtask

    // Plays the master from the LAUNCH cycle on; done/err offsets are relative to the m_start cycle.
    task automatic serve(input bit use_fp, input int busy_n, input int done_at, input int err_at,
                         output int starts, output int start_at, output int cpl_at,
                         output logic id, output logic err, output logic to);
        starts = 0; start_at = -1; cpl_at = -1;
        id = 1'b0; err = 1'b0; to = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            m_busy = (cyc < busy_n);
            m_done = (start_at >= 0) && (cyc - start_at == done_at);
            m_err  = (start_at >= 0) && (cyc - start_at == err_at);
            #1;
            if (use_fp ? f_m_start : a_m_start) begin
                starts++;
                if (start_at < 0) start_at = cyc;
            end
            if (use_fp ? f_cpl_valid : a_cpl_valid) begin
                cpl_at = (start_at >= 0) ? cyc - start_at : cyc;
                id  = use_fp ? f_cpl_id : a_cpl_id;
                err = use_fp ? f_cpl_err : a_cpl_err;
                to  = use_fp ? f_cpl_timeout : a_cpl_timeout;
                break;
            end
            @(posedge HCLK);
            #1;
        end
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_m_start, a_cpl_valid, a_cpl_err, a_cpl_timeout, a_cpl_id} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {a_m_start, a_cpl_valid, a_cpl_err, a_cpl_timeout, a_cpl_id});
        end
        checks++;
        if ({a_m_addr, a_m_write, a_m_size, a_m_burst, a_m_burst_len} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_cmd: got addr=%0h len=%0d expected 0", a_m_addr, a_m_burst_len);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({a_req1_ready, a_req0_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_first_tie: got %b expected 01", {a_req1_ready, a_req0_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        int starts, start_at, cpl_at;
        logic id, err, to;
        exp_t e;
        do_reset();
        req0_addr = 8'h10; req0_write = 1'b1; req0_size = 3'd2; req0_burst = 3'd3; req0_len = 4'd4;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (a_req0_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b expected 1", a_req0_ready);
        end
        sbq.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({a_m_addr, a_m_write, a_m_size, a_m_burst, a_m_burst_len} !== {8'h10, 1'b1, 3'd2, 3'd3, 4'd4}) begin
            failures++;
            $display("[TB] FAIL single_latch: got addr=%0h w=%b sz=%0d b=%0d len=%0d expected 10 1 2 3 4",
                     a_m_addr, a_m_write, a_m_size, a_m_burst, a_m_burst_len);
        end
        serve(1'b0, 0, 6, -1, starts, start_at, cpl_at, id, err, to);
        checks++;
        if (starts !== 1 || cpl_at !== 7) begin
            failures++;
            $display("[TB] FAIL single_timing: got starts=%0d cpl_at=%0d expected 1 7", starts, cpl_at);
        end
        e = sbq.pop_front();
        checks++;
        if ({id, err, to} !== {e.id, e.err, e.to}) begin
            failures++;
            $display("[TB] FAIL single_cpl: got %b expected %b", {id, err, to}, {e.id, e.err, e.to});
        end
        checks++;
        if (a_m_addr !== 8'h10) begin
            failures++;
            $display("[TB] FAIL single_hold: got %0h expected 10", a_m_addr);
        end
    endtask

    task automatic test_back_to_back();
        int starts, start_at, cpl_at;
        logic id, err, to;
        logic exp_g;
        exp_t e;
        do_reset();
        req0_addr = 8'h20; req0_write = 1'b1; req0_len = 4'd2;
        req1_addr = 8'h40; req1_write = 1'b0; req1_len = 4'd3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int r = 0; r < 4; r++) begin
            exp_g = r[0];
            checks++;
            if ({a_req1_ready, a_req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d: got %b expected %b", r, {a_req1_ready, a_req0_ready},
                         exp_g ? 2'b10 : 2'b01);
            end
            sbq.push_back('{id: exp_g, err: 1'b0, to: 1'b0});
            tick();
            checks++;
            if ({a_req1_ready, a_req0_ready} !== 2'b00 || a_m_addr !== (exp_g ? 8'h40 : 8'h20)) begin
                failures++;
                $display("[TB] FAIL rr_pulse%0d: got ready=%b addr=%0h expected 00 %0h", r,
                         {a_req1_ready, a_req0_ready}, a_m_addr, exp_g ? 8'h40 : 8'h20);
            end
            serve(1'b0, 0, 2, -1, starts, start_at, cpl_at, id, err, to);
            e = sbq.pop_front();
            checks++;
            if ({id, err, to} !== {e.id, e.err, e.to} || cpl_at !== 3) begin
                failures++;
                $display("[TB] FAIL rr_cpl%0d: got %b at %0d expected %b at 3", r, {id, err, to}, cpl_at,
                         {e.id, e.err, e.to});
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        int starts, start_at, cpl_at;
        logic id, err, to;
        exp_t e;
        do_reset();
        req0_addr = 8'h21; req0_len = 4'd1;
        req1_addr = 8'h41; req1_len = 4'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int r = 0; r < 3; r++) begin
            checks++;
            if ({f_req1_ready, f_req0_ready} !== 2'b01) begin
                failures++;
                $display("[TB] FAIL fixed_grant%0d: got %b expected 01", r, {f_req1_ready, f_req0_ready});
            end
            sbq.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
            tick();
            serve(1'b1, 0, 2, -1, starts, start_at, cpl_at, id, err, to);
            e = sbq.pop_front();
            checks++;
            if ({id, err, to} !== {e.id, e.err, e.to} || f_m_addr !== 8'h21) begin
                failures++;
                $display("[TB] FAIL fixed_cpl%0d: got %b addr=%0h expected %b addr=21", r, {id, err, to},
                         f_m_addr, {e.id, e.err, e.to});
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_error();
        int starts, start_at, cpl_at;
        logic id, err, to;
        exp_t e;
        do_reset();
        req1_addr = 8'h80; req1_len = 4'd2;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({a_req1_ready, a_req0_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL err_ready: got %b expected 10", {a_req1_ready, a_req0_ready});
        end
        sbq.push_back('{id: 1'b1, err: 1'b1, to: 1'b0});
        tick();
        req1_valid = 1'b0;
        serve(1'b0, 0, 4, 2, starts, start_at, cpl_at, id, err, to);
        e = sbq.pop_front();
        checks++;
        if ({id, err, to} !== {e.id, e.err, e.to} || cpl_at !== 5) begin
            failures++;
            $display("[TB] FAIL err_cpl: got %b at %0d expected %b at 5", {id, err, to}, cpl_at,
                     {e.id, e.err, e.to});
        end
    endtask

    task automatic test_timeout();
        int starts, start_at, cpl_at;
        logic id, err, to;
        exp_t e;
        do_reset();
        req0_addr = 8'h33; req0_len = 4'd4;
        req0_valid = 1'b1;
        #1;
        sbq.push_back('{id: 1'b0, err: 1'b1, to: 1'b1});
        tick();
        req0_valid = 1'b0;
        serve(1'b0, 0, -1, -1, starts, start_at, cpl_at, id, err, to);
        e = sbq.pop_front();
        checks++;
        if ({id, err, to} !== {e.id, e.err, e.to} || cpl_at !== 8) begin
            failures++;
            $display("[TB] FAIL timeout_cpl: got %b at %0d expected %b at 8", {id, err, to}, cpl_at,
                     {e.id, e.err, e.to});
        end
        checks++;
        if (f_cpl_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_disabled: got %b expected 0", f_cpl_valid);
        end
        tick();
        req0_valid = 1'b1;
        #1;
        sbq.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        tick();
        req0_valid = 1'b0;
        serve(1'b0, 0, 7, -1, starts, start_at, cpl_at, id, err, to);
        e = sbq.pop_front();
        checks++;
        if ({id, err, to} !== {e.id, e.err, e.to} || cpl_at !== 8) begin
            failures++;
            $display("[TB] FAIL timeout_done_wins: got %b at %0d expected %b at 8", {id, err, to}, cpl_at,
                     {e.id, e.err, e.to});
        end
    endtask

    task automatic test_len0_busy();
        int starts, start_at, cpl_at;
        logic id, err, to;
        exp_t e;
        do_reset();
        req0_addr = 8'h44; req0_len = 4'd0;
        req0_valid = 1'b1;
        #1;
        sbq.push_back('{id: 1'b0, err: 1'b1, to: 1'b0});
        tick();
        req0_valid = 1'b0;
        serve(1'b0, 0, -1, -1, starts, start_at, cpl_at, id, err, to);
        e = sbq.pop_front();
        checks++;
        if (starts !== 0 || cpl_at !== 0 || {id, err, to} !== {e.id, e.err, e.to}) begin
            failures++;
            $display("[TB] FAIL len0: got starts=%0d at %0d cpl=%b expected 0 at 0 cpl=%b", starts, cpl_at,
                     {id, err, to}, {e.id, e.err, e.to});
        end
        tick();
        req0_len = 4'd1;
        req0_valid = 1'b1;
        #1;
        sbq.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        tick();
        req0_valid = 1'b0;
        serve(1'b0, 3, 2, -1, starts, start_at, cpl_at, id, err, to);
        e = sbq.pop_front();
        checks++;
        if (starts !== 1 || start_at !== 3 || cpl_at !== 3 || {id, err, to} !== {e.id, e.err, e.to}) begin
            failures++;
            $display("[TB] FAIL busy_hold: got starts=%0d start_at=%0d cpl_at=%0d expected 1 3 3",
                     starts, start_at, cpl_at);
        end
    endtask

    task automatic test_reset_mid();
        int cpl_seen;
        do_reset();
        req0_addr = 8'h55; req0_len = 4'd4;
        req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({a_m_start, a_cpl_valid, a_m_addr, a_m_burst_len} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got start=%b cpl=%b addr=%0h len=%0d expected 0",
                     a_m_start, a_cpl_valid, a_m_addr, a_m_burst_len);
        end
        tick();
        HRESETn = 1'b1;
        cpl_seen = 0;
        for (int c = 0; c < 12; c++) begin
            m_done = (c == 1);
            #1;
            if (a_cpl_valid) cpl_seen++;
            tick();
        end
        m_done = 1'b0;
        checks++;
        if (cpl_seen !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_nocpl: got %0d completions expected 0", cpl_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fixed_prio();
        test_error();
        test_timeout();
        test_len0_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
